// File: rtl/sram_like_arbiter.sv
// Two-client SRAM-like bus arbiter with an in-order response ID FIFO.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed data-first priority.
module sram_like_arbiter #(
  parameter int OST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic [3:0]  ost_cnt,
  output logic        resp_err
);

  localparam int PW = $clog2(OST_DEPTH);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic                 hold_id_r;
  logic [OST_DEPTH-1:0] id_fifo_r;
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [3:0]           cnt_r;
  logic                 resp_err_r;

  logic arb_id_s, sel_id_s, sel_req_s, not_full_s, m_req_s;
  logic push_s, pop_s, head_id_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_data_r;

  // Priority flips to the requester that was not granted on each acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_data_r <= 1'b1;
    end else if (push_s) begin
      prio_data_r <= ~sel_id_s;
    end
  end

  assign arb_id_s = (inst_req & data_req) ? prio_data_r : data_req;
`else
  assign arb_id_s = data_req;
`endif

  assign not_full_s = (cnt_r < 4'(OST_DEPTH));
  assign head_id_s  = id_fifo_r[rd_ptr_r];

  // Select the requester driving the master side: free arbitration or locked grant
  always_comb begin
    sel_id_s  = 1'b0;
    sel_req_s = 1'b0;
    case (state_r)
      ARB: begin
        sel_id_s  = arb_id_s;
        sel_req_s = inst_req | data_req;
      end
      HOLD: begin
        sel_id_s  = hold_id_r;
        sel_req_s = hold_id_r ? data_req : inst_req;
      end
      default: begin
        sel_id_s  = 1'b0;
        sel_req_s = 1'b0;
      end
    endcase
  end

  assign m_req_s = ~reset & sel_req_s & not_full_s;
  assign push_s  = m_req_s & m_addr_ok;
  assign pop_s   = ~reset & m_data_ok & (cnt_r != 4'd0);

  // Master-side request mux, forced quiet while reset is asserted
  always_comb begin
    m_req   = m_req_s;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (reset) begin
      m_wr    = 1'b0;
    end else if (sel_id_s) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = push_s & ~sel_id_s;
  assign data_addr_ok = push_s & sel_id_s;
  assign inst_data_ok = pop_s & ~head_id_s;
  assign data_data_ok = pop_s & head_id_s;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign ost_cnt      = reset ? 4'd0 : cnt_r;
  assign resp_err     = reset ? 1'b0 : resp_err_r;

  // Grant locks when the slave stalls; released on acceptance or requester withdrawal
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB: begin
        if (m_req_s & ~m_addr_ok) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ARB;
        end
      end
      HOLD: begin
        if (push_s | ~sel_req_s) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ARB;
    endcase
  end

  // State, locked ID and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ARB;
      hold_id_r  <= 1'b0;
      resp_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ARB) begin
        hold_id_r <= sel_id_s;
      end
      if (m_data_ok & (cnt_r == 4'd0)) begin
        resp_err_r <= 1'b1;
      end
    end
  end

  // In-order ID FIFO; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      id_fifo_r <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      cnt_r     <= 4'd0;
    end else begin
      if (push_s) begin
        id_fifo_r[wr_ptr_r] <= sel_id_s;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 4'd1;
        2'b01:   cnt_r <= cnt_r - 4'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios then randomized traffic
// checked against a queue-based model of grant and response ordering.
module tb_sram_like_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  ost_cnt;
  logic        resp_err;

  sram_like_arbiter #(.OST_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .ost_cnt(ost_cnt), .resp_err(resp_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of accepted requester IDs (0=inst, 1=data) in acceptance order
  bit id_q[$];
  bit lock_v, lock_id, rr_pref, err_m;
  bit w_e, mreq_e, push_e, pop_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rst, input bit ireq, input bit dreq, input bit aok, input bit dok);
    reset      = rst;
    inst_req   = ireq;
    data_req   = dreq;
    m_addr_ok  = aok;
    m_data_ok  = dok;
    inst_wr    = 1'($urandom);
    data_wr    = 1'($urandom);
    inst_size  = 2'($urandom);
    data_size  = 2'($urandom);
    inst_addr  = $urandom;
    data_addr  = $urandom;
    inst_wdata = $urandom;
    data_wdata = $urandom;
    m_rdata    = $urandom;
  endtask

  // Settle, compute expectations from the model, compare every output
  task automatic eval();
    bit wreq;
    #1;
    chk("inst_rdata", inst_rdata, m_rdata);
    chk("data_rdata", data_rdata, m_rdata);
    if (reset) begin
      mreq_e = 1'b0; push_e = 1'b0; pop_e = 1'b0; w_e = 1'b0;
      chk("rst_m_req", m_req, 0);
      chk("rst_m_wr", m_wr, 0);
      chk("rst_m_size", m_size, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
      chk("rst_ost_cnt", ost_cnt, 0);
      chk("rst_resp_err", resp_err, 0);
    end else begin
      if (lock_v) begin
        w_e  = lock_id;
        wreq = lock_id ? data_req : inst_req;
      end else begin
        wreq = inst_req | data_req;
`ifdef ARB_ROUND_ROBIN_EN
        w_e = (inst_req && data_req) ? rr_pref : data_req;
`else
        w_e = data_req;
`endif
      end
      mreq_e = wreq && (id_q.size() < DEPTH);
      push_e = mreq_e && m_addr_ok;
      pop_e  = m_data_ok && (id_q.size() > 0);
      chk("m_req", m_req, mreq_e);
      chk("inst_addr_ok", inst_addr_ok, push_e && !w_e);
      chk("data_addr_ok", data_addr_ok, push_e && w_e);
      chk("inst_data_ok", inst_data_ok, pop_e && !id_q[0]);
      chk("data_data_ok", data_data_ok, pop_e && id_q[0]);
      chk("ost_cnt", ost_cnt, id_q.size());
      chk("resp_err", resp_err, err_m);
      if (mreq_e) begin
        chk("m_addr", m_addr, w_e ? data_addr : inst_addr);
        chk("m_wdata", m_wdata, w_e ? data_wdata : inst_wdata);
        chk("m_wr", m_wr, w_e ? data_wr : inst_wr);
        chk("m_size", m_size, w_e ? data_size : inst_size);
      end
    end
  endtask

  // Clock edge, then advance the model
  task automatic adv();
    @(posedge clk);
    if (reset) begin
      id_q.delete();
      lock_v = 1'b0; lock_id = 1'b0; rr_pref = 1'b1; err_m = 1'b0;
    end else begin
      if (pop_e) void'(id_q.pop_front());
      else if (m_data_ok) err_m = 1'b1;
      if (push_e) begin
        id_q.push_back(w_e);
        lock_v  = 1'b0;
        rr_pref = !w_e;
      end else if (mreq_e) begin
        lock_v  = 1'b1;
        lock_id = w_e;
      end else begin
        lock_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step(input bit rst, input bit ireq, input bit dreq, input bit aok, input bit dok);
    set_in(rst, ireq, dreq, aok, dok);
    eval();
    adv();
  endtask

  initial begin
    lock_v = 1'b0; lock_id = 1'b0; rr_pref = 1'b1; err_m = 1'b0;
    // Reset: outputs quiet even with slave activity
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);

    // Both requesting, slave always ready: data wins first
    set_in(0, 1, 1, 1, 0); eval();
    chk("d021_data_addr_ok", data_addr_ok, 1);
    chk("d021_m_addr", m_addr, data_addr);
    adv();
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1);

    // Stalled data request keeps the grant while inst arrives
    step(0, 0, 1, 0, 0);
    set_in(0, 1, 1, 0, 0); eval();
    chk("d022_m_addr_held", m_addr, data_addr);
    chk("d022_inst_addr_ok", inst_addr_ok, 0);
    adv();
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1);

    // Fill with I,D,D,I then drain in order
    step(0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    set_in(0, 1, 1, 1, 0); eval();
    chk("d023_full_cnt", ost_cnt, 4);
    chk("d023_full_m_req", m_req, 0);
    adv();
    set_in(0, 0, 0, 0, 1); eval(); chk("d023_rsp0_inst", inst_data_ok, 1); adv();
    set_in(0, 0, 0, 0, 1); eval(); chk("d023_rsp1_data", data_data_ok, 1); adv();
    set_in(0, 0, 0, 0, 1); eval(); chk("d023_rsp2_data", data_data_ok, 1); adv();
    set_in(0, 0, 0, 0, 1); eval(); chk("d023_rsp3_inst", inst_data_ok, 1); adv();
    set_in(0, 0, 0, 0, 0); eval(); chk("d023_empty", ost_cnt, 0); adv();

    // Full with simultaneous response and pending request
    repeat (4) step(0, 0, 1, 1, 0);
    set_in(0, 0, 1, 1, 1); eval();
    chk("d024_full_pop_m_req", m_req, 0);
    chk("d024_full_cnt", ost_cnt, 4);
    adv();
    set_in(0, 0, 1, 1, 0); eval();
    chk("d024_next_m_req", m_req, 1);
    adv();
    repeat (4) step(0, 0, 0, 0, 1);

    // Orphan response sets the sticky error
    set_in(0, 0, 0, 0, 1); eval();
    chk("d025_no_data_ok", {inst_data_ok, data_data_ok}, 0);
    adv();
    set_in(0, 0, 0, 0, 0); eval(); chk("d025_err_sticky", resp_err, 1); adv();

    // Reset mid-operation discards outstanding IDs
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    set_in(0, 0, 0, 0, 0); eval(); chk("d018_err_after_rst", resp_err, 1); adv();
    step(1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
